// File: rtl/gpr_port_arbiter.sv
// Purpose: round-robin arbiter/sequencer for the single shared GPR port, two masters.
// Latency: grant 1 cycle after sample; write done +2, read done (with rdata) +3.
// Backpressure: a request is held until gnt; while busy, new requests wait for IDLE.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req*/wr*/addr*/wdata*      master request, op type, address, write data
//   gnt*, done*                one-cycle accept / completion pulses to the masters
//   rdata                      captured read result, held until the next read capture
//   busy                       arbiter is in ISSUE, HOLD or DONE
//   gpr_*                      register file port controls and read data
module gpr_port_arbiter #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] gpr_address_in,
    output logic [ADDR_W-1:0] gpr_address_out,
    output logic [DATA_W-1:0] gpr_data_in,
    input  logic [DATA_W-1:0] gpr_data_out,
    output logic              gpr_rd,
    output logic              gpr_wr
);

    // A read addresses three REG_W-wide fields, so the address must hold them.
    generate
        if (ADDR_W < 3 * REG_W) begin : g_bad_params
            $error("gpr_port_arbiter: ADDR_W must hold three REG_W fields");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // win_q: 1 = master 1 owns the current op. last_q: master served most recently.
    logic win_q, win_d;
    logic op_wr_q, op_wr_d;
    logic last_q, last_d;

    logic              gnt0_d, gnt1_d, done0_d, done1_d, busy_d;
    logic              gpr_rd_d, gpr_wr_d;
    logic [DATA_W-1:0] rdata_d, gpr_data_in_d;
    logic [ADDR_W-1:0] gpr_address_in_d, gpr_address_out_d;

    // Master 1 wins when it is alone, or on a tie when master 0 was served last.
    logic              pick1;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign pick1     = req1 & (~req0 | ~last_q);
    assign sel_wr    = pick1 ? wr1    : wr0;
    assign sel_addr  = pick1 ? addr1  : addr0;
    assign sel_wdata = pick1 ? wdata1 : wdata0;

    // Every output is computed here for the next cycle and registered below,
    // so the GPR sees glitch-free controls aligned with the state register.
    always_comb begin
        state_d           = state_q;
        win_d             = win_q;
        op_wr_d           = op_wr_q;
        last_d            = last_q;
        gnt0_d            = 1'b0;
        gnt1_d            = 1'b0;
        done0_d           = 1'b0;
        done1_d           = 1'b0;
        gpr_rd_d          = 1'b0;
        gpr_wr_d          = 1'b0;
        rdata_d           = rdata;
        gpr_address_in_d  = gpr_address_in;
        gpr_address_out_d = gpr_address_out;
        gpr_data_in_d     = gpr_data_in;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_ISSUE;
                    win_d   = pick1;
                    op_wr_d = sel_wr;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    // Only the bus for this op moves; the other keeps its value.
                    if (sel_wr) begin
                        gpr_wr_d         = 1'b1;
                        gpr_address_in_d = sel_addr;
                        gpr_data_in_d    = sel_wdata;
                    end else begin
                        gpr_rd_d          = 1'b1;
                        gpr_address_out_d = sel_addr;
                    end
                end
            end
            S_ISSUE: begin
                if (op_wr_q) begin
                    state_d = S_DONE;
                    done0_d = ~win_q;
                    done1_d = win_q;
                end else begin
                    // Second read cycle gives the GPR's adder time to settle.
                    state_d  = S_HOLD;
                    gpr_rd_d = 1'b1;
                end
            end
            S_HOLD: begin
                state_d = S_DONE;
                rdata_d = gpr_data_out;
                done0_d = ~win_q;
                done1_d = win_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
                last_d  = win_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            win_q           <= 1'b0;
            op_wr_q         <= 1'b0;
            last_q          <= 1'b1;
            gnt0            <= 1'b0;
            gnt1            <= 1'b0;
            done0           <= 1'b0;
            done1           <= 1'b0;
            busy            <= 1'b0;
            gpr_rd          <= 1'b0;
            gpr_wr          <= 1'b0;
            rdata           <= '0;
            gpr_address_in  <= '0;
            gpr_address_out <= '0;
            gpr_data_in     <= '0;
        end else begin
            state_q         <= state_d;
            win_q           <= win_d;
            op_wr_q         <= op_wr_d;
            last_q          <= last_d;
            gnt0            <= gnt0_d;
            gnt1            <= gnt1_d;
            done0           <= done0_d;
            done1           <= done1_d;
            busy            <= busy_d;
            gpr_rd          <= gpr_rd_d;
            gpr_wr          <= gpr_wr_d;
            rdata           <= rdata_d;
            gpr_address_in  <= gpr_address_in_d;
            gpr_address_out <= gpr_address_out_d;
            gpr_data_in     <= gpr_data_in_d;
        end
    end

endmodule

// File: tb/tb_gpr_port_arbiter.sv
// Purpose: self-checking bench for gpr_port_arbiter with a GPR model and a schedule-based reference.
// Latency: reference predicts every output per cycle from the request timeline.
// Backpressure: masters hold req until gnt; all waits are bounded.
module tb_gpr_port_arbiter;
    localparam int DW = 14;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n, req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, busy, gpr_rd, gpr_wr;
    logic [DW-1:0] rdata, gpr_data_in, gpr_data_out;
    logic [AW-1:0] gpr_address_in, gpr_address_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gpr_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .REG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy),
        .gpr_address_in(gpr_address_in), .gpr_address_out(gpr_address_out),
        .gpr_data_in(gpr_data_in), .gpr_data_out(gpr_data_out),
        .gpr_rd(gpr_rd), .gpr_wr(gpr_wr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Register file: write on the write field, read returns the three-field sum.
    logic [DW-1:0] gpr_regs [16] = '{default: '0};
    always @(posedge clk) if (gpr_wr === 1'b1) gpr_regs[gpr_address_in[11:8]] <= gpr_data_in;
    assign gpr_data_out = gpr_regs[gpr_address_out[11:8]] + gpr_regs[gpr_address_out[7:4]]
                        + gpr_regs[gpr_address_out[3:0]];

    // Reference: each accepted request writes its expected output events into
    // a small timeline indexed by edge number; held buses update when their
    // event comes due.
    typedef struct packed {
        logic g0, g1, d0, d1, rd, wr, busy, ain_v, aout_v, din_v, rdat_v;
        logic [AW-1:0] ain, aout;
        logic [DW-1:0] din, rdat;
    } ev_t;

    ev_t           sched [8];
    ev_t           m_cur;
    logic [AW-1:0] m_ain, m_aout, m_addr;
    logic [DW-1:0] m_din, m_rdat, m_wdat;
    logic [DW-1:0] ref_regs [16] = '{default: '0};
    logic          m_ok = 1'b0;
    logic          m_last, m_w, m_wr;
    logic [2:0]    s0, s1, s2;
    int            edge_n = 0;
    int            m_free = 0;

    function automatic logic [DW-1:0] ref_sum(input logic [AW-1:0] a);
        return ref_regs[a[11:8]] + ref_regs[a[7:4]] + ref_regs[a[3:0]];
    endfunction

    always @(posedge clk) begin
        edge_n++;
        s0 = edge_n[2:0];
        s1 = s0 + 3'd1;
        s2 = s0 + 3'd2;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) sched[i] = '0;
            m_cur  = '0;
            m_ain  = '0;
            m_aout = '0;
            m_din  = '0;
            m_rdat = '0;
            m_last = 1'b1;
            m_free = edge_n + 1;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            if (edge_n >= m_free && (req0 || req1)) begin
                m_w    = (req0 && req1) ? !m_last : req1;
                m_wr   = m_w ? wr1 : wr0;
                m_addr = m_w ? addr1 : addr0;
                m_wdat = m_w ? wdata1 : wdata0;
                sched[s0].g0   = !m_w;
                sched[s0].g1   = m_w;
                sched[s0].busy = 1'b1;
                sched[s1].busy = 1'b1;
                if (m_wr) begin
                    sched[s0].wr    = 1'b1;
                    sched[s0].ain_v = 1'b1;
                    sched[s0].ain   = m_addr;
                    sched[s0].din_v = 1'b1;
                    sched[s0].din   = m_wdat;
                    sched[s1].d0    = !m_w;
                    sched[s1].d1    = m_w;
                    ref_regs[m_addr[11:8]] = m_wdat;
                    m_free = edge_n + 3;
                end else begin
                    sched[s0].rd     = 1'b1;
                    sched[s0].aout_v = 1'b1;
                    sched[s0].aout   = m_addr;
                    sched[s1].rd     = 1'b1;
                    sched[s2].busy   = 1'b1;
                    sched[s2].d0     = !m_w;
                    sched[s2].d1     = m_w;
                    sched[s2].rdat_v = 1'b1;
                    sched[s2].rdat   = ref_sum(m_addr);
                    m_free = edge_n + 4;
                end
                m_last = m_w;
            end
            m_cur = sched[s0];
            sched[s0] = '0;
            if (m_cur.ain_v)  m_ain  = m_cur.ain;
            if (m_cur.aout_v) m_aout = m_cur.aout;
            if (m_cur.din_v)  m_din  = m_cur.din;
            if (m_cur.rdat_v) m_rdat = m_cur.rdat;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("gnt0", 32'(gnt0), 32'(m_cur.g0));
            check("gnt1", 32'(gnt1), 32'(m_cur.g1));
            check("done0", 32'(done0), 32'(m_cur.d0));
            check("done1", 32'(done1), 32'(m_cur.d1));
            check("gpr_rd", 32'(gpr_rd), 32'(m_cur.rd));
            check("gpr_wr", 32'(gpr_wr), 32'(m_cur.wr));
            check("busy", 32'(busy), 32'(m_cur.busy));
            check("gpr_address_in", 32'(gpr_address_in), 32'(m_ain));
            check("gpr_address_out", 32'(gpr_address_out), 32'(m_aout));
            check("gpr_data_in", 32'(gpr_data_in), 32'(m_din));
            check("rdata", 32'(rdata), 32'(m_rdat));
            check("rd_wr_exclusive", 32'(gpr_rd & gpr_wr), 32'd0);
            check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        end
    end

    // One complete operation for master m, with bounded waits for gnt and done.
    task automatic op(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t;
        @(negedge clk);
        if (m == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(m == 0 ? gnt0 : gnt1) && t < 20);
        check("op_gnt_seen", 32'(m == 0 ? gnt0 : gnt1), 32'd1);
        if (m == 0) req0 = 1'b0; else req1 = 1'b0;
        t = 0;
        while (!(m == 0 ? done0 : done1) && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("op_done_seen", 32'(m == 0 ? done0 : done1), 32'd1);
    endtask

    int order[$];
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};
    int c_g0, c_d1;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_addr_in", 32'(gpr_address_in), 32'd0);

        // Single write from master 0.
        rst_n = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h300; wdata0 = 14'h1ABC;
        @(negedge clk);
        check("w_gnt0", 32'(gnt0), 32'd1);
        check("w_gpr_wr", 32'(gpr_wr), 32'd1);
        check("w_addr_in", 32'(gpr_address_in), 32'h300);
        check("w_data_in", 32'(gpr_data_in), 32'h1ABC);
        req0 = 1'b0;
        @(negedge clk);
        check("w_done0", 32'(done0), 32'd1);
        check("w_wr_low_done", 32'(gpr_wr), 32'd0);
        @(negedge clk);
        check("w_idle_busy", 32'(busy), 32'd0);

        // Read of regs 1,2,3 = 2,3,4 by master 1.
        op(1, 1'b1, 12'h100, 14'd2);
        op(0, 1'b1, 12'h200, 14'd3);
        op(1, 1'b1, 12'h300, 14'd4);
        @(negedge clk);
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h123;
        @(negedge clk);
        check("r_gnt1", 32'(gnt1), 32'd1);
        check("r_rd_issue", 32'(gpr_rd), 32'd1);
        check("r_addr_out", 32'(gpr_address_out), 32'h123);
        req1 = 1'b0;
        @(negedge clk);
        check("r_rd_hold", 32'(gpr_rd), 32'd1);
        check("r_no_early_done", 32'(done1), 32'd0);
        @(negedge clk);
        check("r_done1", 32'(done1), 32'd1);
        check("r_rd_low_done", 32'(gpr_rd), 32'd0);
        check("r_rdata", 32'(rdata), 32'd9);
        op(0, 1'b1, 12'h500, 14'h77);
        op(1, 1'b1, 12'h600, 14'h88);
        check("r_rdata_held", 32'(rdata), 32'd9);

        // Wrapping sum.
        op(0, 1'b1, 12'h000, 14'h3FFF);
        op(1, 1'b1, 12'h100, 14'h3FFF);
        op(0, 1'b1, 12'h200, 14'h3FFF);
        op(0, 1'b0, 12'h012, 14'h0);
        check("ovf_rdata", 32'(rdata), 32'h3FFD);

        // Fairness from reset with both masters requesting continuously.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h700; wdata0 = 14'h55;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h777;
        order.delete();
        for (int t = 0; t < 80 && order.size() < 6; t++) begin
            @(negedge clk);
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
            if (order.size() >= 6) begin req0 = 1'b0; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
        end
        check("fair_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check("fair_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(exp_order[i]));

        // Reset during the HOLD of a read.
        @(negedge clk);
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h123;
        @(negedge clk);
        check("rst_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        @(negedge clk);
        check("rst_in_hold", 32'(gpr_rd), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_gpr_rd", 32'(gpr_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_addr_in", 32'(gpr_address_in), 32'd0);
        check("rst_addr_out", 32'(gpr_address_out), 32'd0);
        check("rst_data_in", 32'(gpr_data_in), 32'd0);
        rst_n = 1'b1;
        c_d1 = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (done1) c_d1++;
        end
        check("rst_no_done", 32'(c_d1), 32'd0);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h800; wdata0 = 14'h11;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 12'h900; wdata1 = 14'h22;
        @(negedge clk);
        check("tie_gnt0", 32'(gnt0), 32'd1);
        check("tie_gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0;
        for (int t = 0; t < 20 && !gnt1; t++) @(negedge clk);
        check("tie_then_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        repeat (4) @(negedge clk);

        // One-cycle req0 pulse while master 1 is being served.
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h012;
        @(negedge clk);
        check("pulse_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'hA00; wdata0 = 14'h1;
        @(negedge clk);
        req0 = 1'b0;
        c_g0 = 0; c_d1 = 0;
        for (int t = 0; t < 10; t++) begin
            if (gnt0) c_g0++;
            if (done1) c_d1++;
            @(negedge clk);
        end
        check("pulse_no_gnt0", 32'(c_g0), 32'd0);
        check("pulse_one_done1", 32'(c_d1), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
